mix_columns_iter: RTL and testbench

//   Sequential AES MixColumns / InvMixColumns unit for the SIMD vector datapath.

---
 rtl/aes_gf_pkg.sv | 29 ++
 rtl/mix_column_word.sv | 37 +++
 rtl/mix_columns_iter.sv | 101 ++++++++++
 tb/tb_mix_columns_iter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers and shared types for the iterative AES MixColumns unit.
package aes_gf_pkg;

   localparam logic [7:0] AES_POLY = 8'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mc_state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   // Shift-and-add multiply; the constant operand is one of the small matrix coefficients.
   function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] k);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = b;
      for (int i = 0; i < 8; i++) begin
         if (k[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns of one 32-bit AES column (row 0 in bits [31:24]).
module mix_column_word
   import aes_gf_pkg::*;
(
   input  logic [31:0] col,
   input  logic        inv,
   output logic [31:0] mixed
);

   logic [7:0] a    [4];
   logic [7:0] coef [4];
   logic [7:0] r    [4];
   logic [1:0] sel;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         a[i] = col[31-8*i -: 8];
      end
      if (inv) begin
         coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
      end else begin
         coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      end
      sel   = 2'd0;
      mixed = 32'h0;
      // Row i uses the coefficient row rotated right by i.
      for (int i = 0; i < 4; i++) begin
         r[i] = 8'h00;
         for (int j = 0; j < 4; j++) begin
            sel  = 2'(j - i);
            r[i] = r[i] ^ gf_mul(a[j], coef[sel]);
         end
         mixed[31-8*i -: 8] = r[i];
      end
   end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns over a vecSize-column state, COLS_PER_CYCLE columns per clock.
//
//   state | meaning
//   IDLE  | in_ready high; waiting for in_valid to capture a new state
//   BUSY  | transforming one column group per clock in the work register
//   DONE  | out_valid high; result held until out_ready
module mix_columns_iter
   import aes_gf_pkg::*;
#(
   parameter int regSize        = 32,
   parameter int vecSize        = 4,
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             inv,
   input  logic [vecSize-1:0][regSize-1:0]  vect,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [vecSize-1:0][regSize-1:0]  new_vect
);

   localparam int CW = $clog2(vecSize) + 1;
   localparam int IW = (vecSize > 1) ? $clog2(vecSize) : 1;
   localparam logic [CW-1:0] LAST_GRP = CW'(vecSize - COLS_PER_CYCLE);
   localparam logic [CW-1:0] STEP     = CW'(COLS_PER_CYCLE);

   mc_state_t                         state, state_nxt;
   logic [CW-1:0]                     col_cnt;
   logic [vecSize-1:0][regSize-1:0]   work;
   logic                              mode;
   logic                              last_grp;
   logic [IW-1:0]                     grp_idx   [COLS_PER_CYCLE];
   logic [regSize-1:0]                grp_mixed [COLS_PER_CYCLE];

   assign last_grp = (col_cnt == LAST_GRP);
   assign new_vect = work;

   // Columns are independent, so each group is read and rewritten in place.
   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      assign grp_idx[g] = IW'(col_cnt + CW'(g));
      mix_column_word u_mix (
         .col   (work[grp_idx[g]]),
         .inv   (mode),
         .mixed (grp_mixed[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = BUSY;
         end
         BUSY: begin
            if (last_grp) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_cnt <= '0;
         work    <= '0;
         mode    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  work    <= vect;
                  mode    <= inv;
                  col_cnt <= '0;
               end
            end
            BUSY: begin
               for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                  work[grp_idx[g]] <= grp_mixed[g];
               end
               col_cnt <= col_cnt + STEP;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Scoreboard bench for mix_columns_iter at COLS_PER_CYCLE = 1, 2 and 4.
module tb_mix_columns_iter;

   typedef logic [3:0][31:0] vec_t;

   localparam vec_t T1    = {32'h7563C5C0, 32'h76757CC5, 32'h7B76D27C, 32'h637BC0D2};
   localparam vec_t E1    = {32'h4A27DCA2, 32'hCADDAF02, 32'hC28636D1, 32'h591CEEA1};
   localparam vec_t K_IN  = {32'hC6C6C6C6, 32'h01010101, 32'hF20A225C, 32'hDB135345};
   localparam vec_t K_OUT = {32'hC6C6C6C6, 32'h01010101, 32'h9FDC589D, 32'h8E4DA1BC};

   logic clk = 1'b0;
   logic rst;
   logic iv [3];
   logic inv_s [3];
   logic ordy [3];
   logic ir [3];
   logic ov [3];
   vec_t vect_s [3];
   vec_t nv [3];

   vec_t sb0[$];
   vec_t sb1[$];
   vec_t sb2[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mix_columns_iter #(.regSize(32), .vecSize(4), .COLS_PER_CYCLE(1)) u_c1 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .inv(inv_s[0]),
      .vect(vect_s[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .new_vect(nv[0]));
   mix_columns_iter #(.regSize(32), .vecSize(4), .COLS_PER_CYCLE(2)) u_c2 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .inv(inv_s[1]),
      .vect(vect_s[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .new_vect(nv[1]));
   mix_columns_iter #(.regSize(32), .vecSize(4), .COLS_PER_CYCLE(4)) u_c4 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .inv(inv_s[2]),
      .vect(vect_s[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .new_vect(nv[2]));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int d, input vec_t e);
      case (d)
         0: sb0.push_back(e);
         1: sb1.push_back(e);
         default: sb2.push_back(e);
      endcase
   endtask

   function automatic int sb_size(input int d);
      case (d)
         0: return sb0.size();
         1: return sb1.size();
         default: return sb2.size();
      endcase
   endfunction

   function automatic vec_t sb_pop(input int d);
      case (d)
         0: return sb0.pop_front();
         1: return sb1.pop_front();
         default: return sb2.pop_front();
      endcase
   endfunction

   // Result is consumed on the next rising edge whenever out_valid and out_ready are both high.
   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 3; d++) begin
            if (ov[d] && ordy[d]) begin
               if (sb_size(d) == 0) begin
                  checks++;
                  errors++;
                  $error("FAIL out_unexpected_d%0d: observed=%h expected=none", d, nv[d]);
               end else begin
                  chk($sformatf("result_d%0d", d), nv[d], sb_pop(d));
               end
            end
         end
      end
   end

   task automatic start(input int d, input vec_t v, input logic i, input vec_t e);
      logic rdy;
      @(posedge clk); #1;
      iv[d]     = 1'b1;
      vect_s[d] = v;
      inv_s[d]  = i;
      push_exp(d, e);
      rdy = ir[d];
      @(posedge clk); #1;
      chk($sformatf("accept_rdy_d%0d", d), 128'(rdy), 128'(1'b1));
      iv[d]     = 1'b0;
      vect_s[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
      inv_s[d]  = ~i;
   endtask

   task automatic wait_done(input int d, input int lat, input string tag);
      int cnt;
      cnt = 0;
      while (!ov[d] && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk(tag, 128'(cnt), 128'(lat));
   endtask

   task automatic release_out(input int d, input string tag);
      ordy[d] = 1'b1;
      @(posedge clk); #1;
      ordy[d] = 1'b0;
      chk({tag, "_ov"}, 128'(ov[d]), 128'(1'b0));
      chk({tag, "_ir"}, 128'(ir[d]), 128'(1'b1));
   endtask

   task automatic stream(input int d);
      vec_t ins  [3];
      vec_t exps [3];
      logic invs [3];
      logic acc;
      int   k;
      int   guard;
      ins  = '{T1, E1, K_IN};
      exps = '{E1, T1, K_OUT};
      invs = '{1'b0, 1'b1, 1'b0};
      @(posedge clk); #1;
      ordy[d] = 1'b1;
      for (int n = 0; n < 3; n++) push_exp(d, exps[n]);
      k = 0;
      guard = 0;
      iv[d]     = 1'b1;
      vect_s[d] = ins[0];
      inv_s[d]  = invs[0];
      while (k < 3 && guard < 60) begin
         acc = ir[d];
         @(posedge clk); #1;
         guard++;
         if (acc) begin
            k++;
            if (k < 3) begin
               vect_s[d] = ins[k];
               inv_s[d]  = invs[k];
            end else begin
               iv[d] = 1'b0;
            end
         end
      end
      iv[d] = 1'b0;
      chk($sformatf("b2b_accepts_d%0d", d), 128'(k), 128'(3));
      guard = 0;
      while (sb_size(d) != 0 && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      chk($sformatf("b2b_drain_d%0d", d), 128'(sb_size(d)), 128'(0));
      ordy[d] = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0; inv_s[d] = 1'b0; ordy[d] = 1'b0; vect_s[d] = '0;
      end
      #12;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_ir_d%0d", d), 128'(ir[d]), 128'(1'b1));
         chk($sformatf("rst_ov_d%0d", d), 128'(ov[d]), 128'(1'b0));
         chk($sformatf("rst_nv_d%0d", d), nv[d], 128'(0));
      end
      @(negedge clk) rst = 1'b0;

      // forward, inverse round trip, known columns
      start(0, T1, 1'b0, E1);
      wait_done(0, 4, "t1_lat");
      release_out(0, "t1_rel");
      start(0, E1, 1'b1, T1);
      wait_done(0, 4, "t2_lat");
      release_out(0, "t2_rel");
      start(0, K_IN, 1'b0, K_OUT);
      wait_done(0, 4, "t3f_lat");
      release_out(0, "t3f_rel");
      start(0, K_OUT, 1'b1, K_IN);
      wait_done(0, 4, "t3i_lat");
      release_out(0, "t3i_rel");

      // backpressure with a competing in_valid pulse
      start(0, T1, 1'b0, E1);
      wait_done(0, 4, "t4_lat");
      for (int c = 0; c < 6; c++) begin
         iv[0] = 1'b1; vect_s[0] = K_IN; inv_s[0] = 1'b1;
         @(posedge clk); #1;
         chk("t4_hold_nv", nv[0], E1);
         chk("t4_hold_ir", 128'(ir[0]), 128'(1'b0));
         chk("t4_hold_ov", 128'(ov[0]), 128'(1'b1));
      end
      iv[0] = 1'b0;
      release_out(0, "t4_rel");
      chk("t4_not_captured", nv[0], E1);

      // asynchronous reset in the middle of BUSY
      start(0, T1, 1'b0, E1);
      @(posedge clk); @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("t5_ov", 128'(ov[0]), 128'(1'b0));
      chk("t5_ir", 128'(ir[0]), 128'(1'b1));
      chk("t5_nv", nv[0], 128'(0));
      void'(sb0.pop_back());
      @(negedge clk) rst = 1'b0;
      start(0, T1, 1'b0, E1);
      wait_done(0, 4, "t5_rerun_lat");
      release_out(0, "t5_rerun_rel");

      // wider datapaths
      start(1, T1, 1'b0, E1);
      wait_done(1, 2, "t6_c2_lat");
      release_out(1, "t6_c2_rel");
      start(2, T1, 1'b0, E1);
      wait_done(2, 1, "t6_c4_lat");
      release_out(2, "t6_c4_rel");

      // back-to-back with out_ready tied high
      stream(0);
      stream(1);
      stream(2);

      for (int d = 0; d < 3; d++) begin
         chk($sformatf("final_sb_empty_d%0d", d), 128'(sb_size(d)), 128'(0));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
